// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instructionmemory (slave).
interface instruction_fetch_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);
endinterface

// File: rtl/instruction_fetch.sv
// PC generation and IF/ID pipeline register with stall, flush and branch/jump redirects.
//
// state  | meaning
// RUN    | normal fetch; stall and flush handled in place
// SQUASH | one cycle after a redirect edge; IF/ID holds the bubble
module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'd40,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 branch_taken,
    input  logic [31:0]          branch_target,
    input  logic                 jump,
    input  logic [25:0]          jump_index,
    instruction_fetch_if.master  imem,
    output logic [31:0]          if_pc,
    output logic [31:0]          if_pc_plus4,
    output logic [31:0]          if_instr,
    output logic                 if_valid,
    output logic [31:0]          fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] jump_target;
    logic [31:0] branch_aligned;
    logic        redirect;

    assign imem.imem_addr = pc;
    assign pc_plus4       = pc + 32'd4;
    assign jump_target    = {if_pc_plus4[31:28], jump_index, 2'b00};
    assign branch_aligned = {branch_target[31:2], 2'b00};
    assign redirect       = jump | branch_taken;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_PC;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
            if_instr    <= NOP_INSTR;
            if_valid    <= 1'b0;
            fetch_count <= 32'd0;
        end else if (redirect) begin
            // Wrong-path instruction is squashed regardless of stall/flush.
            state       <= SQUASH;
            pc          <= jump ? jump_target : branch_aligned;
            if_pc       <= 32'd0;
            if_pc_plus4 <= 32'd0;
            if_instr    <= NOP_INSTR;
            if_valid    <= 1'b0;
        end else begin
            state <= RUN;
            if (flush || (stall && state == SQUASH)) begin
                if_pc       <= 32'd0;
                if_pc_plus4 <= 32'd0;
                if_instr    <= NOP_INSTR;
                if_valid    <= 1'b0;
                if (!stall) begin
                    pc <= pc_plus4;
                end
            end else if (!stall) begin
                pc          <= pc_plus4;
                if_pc       <= pc;
                if_pc_plus4 <= pc_plus4;
                if_instr    <= imem.imem_instr;
                if_valid    <= 1'b1;
                fetch_count <= fetch_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized and directed bench for instruction_fetch against a behavioural pipeline model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;
    logic        if_valid;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:1023];

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_ifpc, m_ifpc4, m_instr, m_cnt;
    logic        m_valid;

    instruction_fetch_if imem_bus ();

    assign imem_bus.imem_instr = mem[imem_bus.imem_addr[11:2]];

    instruction_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_index    (jump_index),
        .imem          (imem_bus.master),
        .if_pc         (if_pc),
        .if_pc_plus4   (if_pc_plus4),
        .if_instr      (if_instr),
        .if_valid      (if_valid),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        check_val("imem_addr",   imem_bus.imem_addr, m_pc);
        check_val("if_pc",       if_pc,              m_ifpc);
        check_val("if_pc_plus4", if_pc_plus4,        m_ifpc4);
        check_val("if_instr",    if_instr,           m_instr);
        check_val("if_valid",    {31'd0, if_valid},  {31'd0, m_valid});
        check_val("fetch_count", fetch_count,        m_cnt);
    endtask

    // One clock edge: drive inputs, advance the model by the architectural rules, compare.
    task automatic step(input logic rs, input logic st, input logic fl, input logic bt,
                        input logic [31:0] tgt, input logic jp, input logic [25:0] ji);
        logic [31:0] fetched;
        logic [31:0] n_pc;
        @(negedge clk);
        reset = rs; stall = st; flush = fl; branch_taken = bt;
        branch_target = tgt; jump = jp; jump_index = ji;
        fetched = mem[m_pc[11:2]];
        if (rs) begin
            m_pc = 32'd40; m_ifpc = 0; m_ifpc4 = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
        end else if (jp || bt) begin
            if (jp) n_pc = (m_ifpc4 & 32'hF000_0000) | ({6'd0, ji} * 4);
            else    n_pc = tgt - (tgt % 4);
            m_pc = n_pc; m_ifpc = 0; m_ifpc4 = 0; m_instr = 0; m_valid = 0;
        end else if (fl) begin
            m_ifpc = 0; m_ifpc4 = 0; m_instr = 0; m_valid = 0;
            if (!st) m_pc = m_pc + 4;
        end else if (!st) begin
            m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_instr = fetched; m_valid = 1;
            m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = $urandom;
        mem[10] = 32'h2008_0005;
        reset = 1; stall = 0; flush = 0; branch_taken = 0;
        branch_target = 0; jump = 0; jump_index = 0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // first fetch after reset loads word 10 with no bubble
        step(0, 0, 0, 0, 0, 0, 0);
        check_val("first_instr", if_instr, 32'h2008_0005);
        check_val("first_addr",  imem_bus.imem_addr, 32'd44);
        run_n(1);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0, 0);
        check_val("stall_addr", imem_bus.imem_addr, 32'd48);
        run_n(1);
        check_val("after_stall_pc", imem_bus.imem_addr, 32'd52);

        step(0, 0, 0, 1, 32'h0000_0103, 0, 0);
        check_val("branch_pc", imem_bus.imem_addr, 32'h0000_0100);
        run_n(1);
        check_val("branch_ifpc", if_pc, 32'h0000_0100);

        // jump beats a simultaneous branch, target uses upper nibble of if_pc_plus4
        step(0, 0, 0, 1, 32'h1000_0004, 0, 0);
        run_n(1);
        step(0, 0, 0, 1, 32'h0000_0200, 1, 26'h000000A);
        check_val("jump_pc", imem_bus.imem_addr, 32'h1000_0028);

        step(0, 0, 0, 1, 32'd56, 0, 0);
        run_n(1);
        step(0, 1, 1, 0, 0, 0, 0);
        check_val("flush_stall_pc", imem_bus.imem_addr, 32'd60);
        step(0, 1, 0, 0, 0, 0, 0);

        // redirect during SQUASH, and stall while in SQUASH
        step(0, 0, 0, 1, 32'h0000_0300, 0, 0);
        step(0, 0, 0, 1, 32'h0000_0400, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        run_n(2);

        step(1, 1, 1, 1, 32'h0000_0500, 1, 26'h3FFFFFF);
        check_val("reset_redirect_pc", imem_bus.imem_addr, 32'd40);
        run_n(1);

        // reach pc = 0xFFFFFFFC via a jump from the 0xF region, then wrap
        step(0, 0, 0, 1, 32'hF000_0000, 0, 0);
        run_n(1);
        step(0, 0, 0, 0, 0, 1, 26'h3FFFFFF);
        check_val("top_pc", imem_bus.imem_addr, 32'hFFFF_FFFC);
        run_n(1);
        check_val("wrap_pc", imem_bus.imem_addr, 32'h0000_0000);
        check_val("wrap_ifpc4", if_pc_plus4, 32'h0000_0000);

        for (int i = 0; i < 400; i++) begin
            logic rs, st, fl, bt, jp;
            rs = ($urandom_range(0, 49) == 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 7) == 0);
            bt = ($urandom_range(0, 9) == 0);
            jp = ($urandom_range(0, 14) == 0);
            step(rs, st, fl, bt, $urandom, jp, 26'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
PC-generation and IF/ID pipeline-register stage of the MIPS core, directly upstream of instructionmemory. Owns the program counter and drives the memory byte address. Captures the returned 32-bit instruction into the IF/ID register and handles stall, flush and branch/jump redirects. Program start is byte address 40 (word 10).

Parameters:
RESET_PC, 32'd40, byte address loaded into the PC on reset; word 10 of instruction memory.
NOP_INSTR, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
clk  in  1  single clock; all state updates on the rising edge
reset  in  1  synchronous, active-high
stall  in  1  hazard unit: hold PC and IF/ID
flush  in  1  squash the IF/ID contents (bubble)
branch_taken  in  1  redirect PC to branch_target
branch_target  in  32  full byte address of the taken branch
jump  in  1  redirect PC to pseudo-direct jump target
jump_index  in  26  instr[25:0] of the jump held in ID
imem_addr  out  32  byte address to instructionmemory; equal to the current PC, combinational
imem_instr  in  32  instruction from instructionmemory, valid in the same cycle
if_pc  out  32  PC of the instruction held in IF/ID
if_pc_plus4  out  32  if_pc + 4
if_instr  out  32  instruction held in IF/ID
if_valid  out  1  IF/ID holds a real (non-bubble) instruction
fetch_count  out  32  number of valid instructions loaded into IF/ID

Behaviour:
- Reset (synchronous, evaluated at a rising edge; overrides every other input):
  - pc <= RESET_PC.
  - if_pc, if_pc_plus4 <= 0; if_instr <= NOP_INSTR; if_valid <= 0; fetch_count <= 0.
- imem_addr = pc, combinational. No bubble is inserted after reset: the first edge after reset is deasserted loads memory[10].
- Jump target = {if_pc_plus4[31:28], jump_index, 2'b00}. Both redirect targets have bits[1:0] forced to 0.
- Per-edge priority (reset deasserted): jump > branch_taken > flush > stall > normal.
  - Redirect (jump or branch_taken):
    - pc <= target.
    - IF/ID <= bubble: if_instr = NOP_INSTR, if_valid = 0, if_pc and if_pc_plus4 = 0.
    - This squashes the wrong-path instruction. Applies even if stall or flush is also asserted.
    - fetch_count is unchanged.
  - flush without redirect: IF/ID <= bubble. pc <= pc + 4 if stall = 0; pc holds if stall = 1.
  - stall only: pc and all IF/ID registers hold; fetch_count holds.
  - Normal operation:
    - pc <= pc + 4.
    - if_instr <= imem_instr, if_pc <= pc, if_pc_plus4 <= pc + 4, if_valid <= 1.
    - fetch_count <= fetch_count + 1.
- Control FSM, two states:
  - RUN: normal, stall or flush operation.
  - SQUASH: entered for exactly one cycle after a redirect edge. Its only effect is to ensure the bubble remains in IF/ID during that cycle.
  - Returns to RUN on the next edge with no new redirect.
  - A redirect while in SQUASH is accepted; the state stays SQUASH.
  - Reset forces RUN.
- Arithmetic is modulo 2^32: pc 0xFFFFFFFC + 4 wraps to 0. fetch_count wraps from 0xFFFFFFFF to 0.
- Reset asserted mid-stall or mid-redirect: the reset values win on that edge, with no residual pending redirect.
- No bounds check against the memory depth. Addresses beyond 996 are a software error.

Test Plan:
- Release reset with memory[10] = 0x20080005, stall, flush and redirects all 0 -> first edge: if_instr = 0x20080005, if_pc = 40, if_pc_plus4 = 44, if_valid = 1, imem_addr = 44, fetch_count = 1.
- Hold stall = 1 for 3 edges starting at pc = 48 -> imem_addr stays 48; if_* and fetch_count unchanged. Release -> loads the instruction at 48; pc becomes 52.
- branch_taken = 1, branch_target = 0x00000103, at pc = 52 -> pc = 0x100; if_valid = 0 and if_instr = 0 on that edge. Next edge: if_pc = 0x100, if_valid = 1.
- jump = 1, jump_index = 0x000000A, with if_pc_plus4 = 0x10000008 -> pc = 0x10000028. Same cycle with branch_taken = 1 -> the jump wins.
- flush = 1 and stall = 1 together at pc = 60 -> IF/ID becomes a bubble; pc holds at 60; fetch_count unchanged.
- Assert reset during a redirect edge; separately force pc to 0xFFFFFFFC -> first case: pc = 40, if_valid = 0, fetch_count = 0. Second case: the next pc is 0.
